// File: rtl/ram_page_reader_pkg.sv
// Shared constants and FSM encoding for the result-RAM page drain engine.
package ram_page_reader_pkg;
  localparam int ROW_BYTES  = 128;
  localparam int BEAT_BYTES = 64;
  localparam int ROW_ADDR_W = 9;
  localparam int PAGE_LEN_W = 17;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_FINISH} state_e;
endpackage

// File: rtl/ram_row_fifo.sv
// Row buffer: full rows written in one cycle, drained as two half-row beats.
module ram_row_fifo
  import ram_page_reader_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          wr,
  input  logic [ROW_BYTES*8-1:0]        wr_data,
  input  logic                          adv,
  input  logic                          last_beat,
  output logic                          valid,
  output logic [BEAT_BYTES*8-1:0]       beat_data,
  output logic [$clog2(DEPTH):0]        free
);
  localparam int AW = $clog2(DEPTH);

  logic [DEPTH-1:0][1:0][BEAT_BYTES*8-1:0] mem;
  logic [AW-1:0] wp, rp;
  logic [AW:0]   cnt;
  logic          half, pop;

  // A row retires after its upper beat, or early when its lower beat ends the page.
  assign pop = adv & (half | last_beat);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp   <= '0;
      rp   <= '0;
      cnt  <= '0;
      half <= 1'b0;
    end else begin
      if (wr) wp <= wp + 1'b1;
      if (pop) begin
        rp   <= rp + 1'b1;
        half <= 1'b0;
      end else if (adv) begin
        half <= 1'b1;
      end
      cnt <= cnt + {{AW{1'b0}}, wr} - {{AW{1'b0}}, pop};
    end
  end

  always_ff @(posedge clk) begin
    if (wr) mem[wp] <= wr_data;
  end

  assign valid     = (cnt != '0);
  assign beat_data = mem[rp][half];
  assign free      = (AW+1)'(DEPTH) - cnt;
endmodule

// File: rtl/ram_page_reader.sv
// Drains a committed page from the result BRAM row by row into 512-bit beats,
// then pulses block_out_finish so the blocks flip valid polarity.
module ram_page_reader
  import ram_page_reader_pkg::*;
#(
  parameter int NUM_BLOCKS     = 16,
  parameter int ROW_FIFO_DEPTH = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic [PAGE_LEN_W-1:0]       page_length,
  input  logic [PAGE_LEN_W-1:0]       committed_bytes,
  output logic                        rd_en,
  output logic [ROW_ADDR_W-1:0]       rd_address,
  input  logic [NUM_BLOCKS*64-1:0]    ram_data_in,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [BEAT_BYTES*8-1:0]     out_data,
  output logic [BEAT_BYTES-1:0]       out_keep,
  output logic                        out_last,
  output logic                        block_out_finish,
  output logic                        busy
);
  localparam int FW = $clog2(ROW_FIFO_DEPTH);

  state_e                  state;
  logic [PAGE_LEN_W-1:0]   len_q, row_end, need;
  logic [9:0]              rows_q, row_cnt, rows_n;
  logic [10:0]             beats_q, beat_cnt, beats_n;
  logic                    rd_pend, fifo_vld, hs, is_last;
  logic [BEAT_BYTES*8-1:0] beat;
  logic [FW:0]             free;
  logic [5:0]              keep_sh;

  assign rows_n  = page_length[16:7] + {9'd0, |page_length[6:0]};
  assign beats_n = page_length[16:6] + {10'd0, |page_length[5:0]};

  // Bytes that must be final before row row_cnt may be read.
  assign row_end = {row_cnt + 10'd1, 7'd0};
  assign need    = (row_end < len_q) ? row_end : len_q;

  // Reads are spaced two cycles apart, so the single pending read is the only
  // one in flight; a row is only issued into a guaranteed free slot.
  assign rd_en = (state == S_RUN) && (row_cnt < rows_q) && (committed_bytes >= need) &&
                 !rd_pend && (free != '0);
  assign rd_address = row_cnt[ROW_ADDR_W-1:0];

  assign hs      = out_valid & out_ready;
  assign is_last = (beat_cnt == beats_q - 11'd1);
  assign keep_sh = 6'd63 - (len_q[5:0] - 6'd1);

  assign out_valid = fifo_vld;
  assign out_data  = fifo_vld ? beat : '0;
  assign out_last  = fifo_vld & is_last;
  assign out_keep  = !fifo_vld ? '0 :
                     is_last   ? ({BEAT_BYTES{1'b1}} >> keep_sh) : '1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_pend <= 1'b0;
    else        rd_pend <= rd_en;
  end

  ram_row_fifo #(.DEPTH(ROW_FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr        (rd_pend),
    .wr_data   (ram_data_in),
    .adv       (hs),
    .last_beat (is_last),
    .valid     (fifo_vld),
    .beat_data (beat),
    .free      (free)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= S_IDLE;
      busy             <= 1'b0;
      block_out_finish <= 1'b0;
      len_q            <= '0;
      rows_q           <= '0;
      beats_q          <= '0;
      row_cnt          <= '0;
      beat_cnt         <= '0;
    end else begin
      if (rd_en) row_cnt  <= row_cnt + 10'd1;
      if (hs)    beat_cnt <= beat_cnt + 11'd1;
      case (state)
        S_IDLE: if (start) begin
          len_q    <= page_length;
          rows_q   <= rows_n;
          beats_q  <= beats_n;
          row_cnt  <= '0;
          beat_cnt <= '0;
          busy     <= 1'b1;
          state    <= (page_length == '0) ? S_FINISH : S_RUN;
        end
        S_RUN: if (rd_en && row_cnt == rows_q - 10'd1) state <= S_DRAIN;
        S_DRAIN: if (hs && is_last) begin
          state            <= S_FINISH;
          block_out_finish <= 1'b1;
        end
        // An empty page arrives here with the pulse not yet raised: raise it
        // for one cycle first, then return to idle.
        S_FINISH: if (block_out_finish) begin
          block_out_finish <= 1'b0;
          busy             <= 1'b0;
          state            <= S_IDLE;
        end else begin
          block_out_finish <= 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule
